// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: fetch/decode/exec/writeback/branch sequencing.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap illegal instructions into a terminal HALT state.
module multicycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic        zero_i,
  input  logic        imem_ack_i,
  output logic        imem_req_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        pc_src_o,
  output logic        reg_write_o,
  output logic        reg_dst_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic        imm_zext_o,
  output logic        shamt_sel_o,
  output logic [3:0]  alu_ctrl_o,
  output logic        tgt_write_o,
  output logic [2:0]  state_o,
  output logic [15:0] retired_o
);

  localparam int unsigned RET_W = 16;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_LUI = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_BRANCH = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic       dec_legal, dec_rtype, dec_shamt, dec_zext;
  logic [3:0] dec_alu;

  // Instruction decode; IR stays stable from DECODE through WB.
  always_comb begin
    dec_legal = 1'b1;
    dec_rtype = 1'b0;
    dec_shamt = 1'b0;
    dec_zext  = 1'b0;
    dec_alu   = ALU_AND;
    case (opcode_i)
      OP_RTYPE: begin
        dec_rtype = 1'b1;
        case (funct_i)
          6'b010011: dec_alu = ALU_ADD;
          6'b010001: dec_alu = ALU_SUB;
          6'b010100: dec_alu = ALU_AND;
          6'b010110: dec_alu = ALU_OR;
          6'b110000: dec_alu = ALU_SLT;
          6'b010101: dec_alu = ALU_NOR;
          6'b000000: begin dec_alu = ALU_SLL; dec_shamt = 1'b1; end
          6'b000010: begin dec_alu = ALU_SRL; dec_shamt = 1'b1; end
          6'b000110: dec_alu = ALU_SLL;
          6'b000100: dec_alu = ALU_SRL;
          default:   dec_legal = 1'b0;
        endcase
      end
      OP_ADDI: dec_alu = ALU_ADD;
      OP_ORI:  begin dec_alu = ALU_OR;  dec_zext = 1'b1; end
      OP_LUI:  begin dec_alu = ALU_LUI; dec_zext = 1'b1; end
      default: dec_legal = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (imem_ack_i) state_nxt = S_DECODE;
      S_DECODE: begin
        if (opcode_i == OP_BEQ) state_nxt = S_BRANCH;
        else if (dec_legal)     state_nxt = S_EXEC;
        else begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          state_nxt = S_HALT;
`else
          state_nxt = S_FETCH;
`endif
        end
      end
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      S_HALT:   state_nxt = S_HALT;
`endif
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Output decode; everything forced low while reset is held.
  always_comb begin
    imem_req_o  = 1'b0;
    ir_write_o  = 1'b0;
    pc_write_o  = 1'b0;
    pc_src_o    = 1'b0;
    reg_write_o = 1'b0;
    reg_dst_o   = 1'b0;
    alu_src_a_o = 1'b0;
    alu_src_b_o = 2'b00;
    imm_zext_o  = 1'b0;
    shamt_sel_o = 1'b0;
    alu_ctrl_o  = 4'b0000;
    tgt_write_o = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          imem_req_o = 1'b1;
          if (imem_ack_i) begin
            ir_write_o  = 1'b1;
            pc_write_o  = 1'b1;
            alu_src_b_o = 2'b01;
            alu_ctrl_o  = ALU_ADD;
          end
        end
        S_DECODE: begin
          tgt_write_o = 1'b1;
          alu_src_b_o = 2'b11;
          alu_ctrl_o  = ALU_ADD;
        end
        S_EXEC, S_WB: begin
          alu_ctrl_o  = dec_alu;
          alu_src_a_o = dec_rtype;
          alu_src_b_o = dec_rtype ? 2'b00 : 2'b10;
          imm_zext_o  = dec_zext;
          shamt_sel_o = dec_shamt;
          if (state == S_WB) begin
            reg_write_o = 1'b1;
            reg_dst_o   = dec_rtype;
          end
        end
        S_BRANCH: begin
          alu_src_a_o = 1'b1;
          alu_ctrl_o  = ALU_SUB;
          pc_write_o  = zero_i;
          pc_src_o    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)
      retired_o <= '0;
    else if (state == S_WB || state == S_BRANCH)
      retired_o <= retired_o + RET_W'(1);
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against an instruction-level reference model.
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode_i, funct_i;
  logic        zero_i, imem_ack_i;
  logic        imem_req_o, ir_write_o, pc_write_o, pc_src_o, reg_write_o, reg_dst_o;
  logic        alu_src_a_o, imm_zext_o, shamt_sel_o, tgt_write_o;
  logic [1:0]  alu_src_b_o;
  logic [3:0]  alu_ctrl_o;
  logic [2:0]  state_o;
  logic [15:0] retired_o;

  int n_checks = 0;
  int n_errors = 0;
  int exp_retired = 0;

  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_n(rst_n), .opcode_i(opcode_i), .funct_i(funct_i),
    .zero_i(zero_i), .imem_ack_i(imem_ack_i), .imem_req_o(imem_req_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .imm_zext_o(imm_zext_o), .shamt_sel_o(shamt_sel_o),
    .alu_ctrl_o(alu_ctrl_o), .tgt_write_o(tgt_write_o), .state_o(state_o),
    .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference instruction table: {legal, rtype, shamt_sel, imm_zext, alu[3:0]}.
  function automatic logic [7:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) begin
      case (fn)
        6'b010011: return {4'b1100, 4'b0010};
        6'b010001: return {4'b1100, 4'b0110};
        6'b010100: return {4'b1100, 4'b0000};
        6'b010110: return {4'b1100, 4'b0001};
        6'b110000: return {4'b1100, 4'b0111};
        6'b010101: return {4'b1100, 4'b1100};
        6'b000000: return {4'b1110, 4'b1000};
        6'b000010: return {4'b1110, 4'b1001};
        6'b000110: return {4'b1100, 4'b1000};
        6'b000100: return {4'b1100, 4'b1001};
        default:   return 8'h00;
      endcase
    end
    if (op == 6'b001000) return {4'b1000, 4'b0010};
    if (op == 6'b001101) return {4'b1001, 4'b0001};
    if (op == 6'b001111) return {4'b1001, 4'b1010};
    return 8'h00;
  endfunction

  // Sum of all write strobes and the fetch request, expected quiet in idle states.
  function automatic logic [3:0] strobes();
    return {ir_write_o | pc_write_o, reg_write_o, tgt_write_o, imem_req_o};
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    rst_n = 1'b0;
    imem_ack_i = 1'b0;
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_retired", 32'(retired_o), 32'd0);
    chk("rst_strobes", 32'({ir_write_o, pc_write_o, reg_write_o, tgt_write_o}), 32'd0);
    exp_retired = 0;
    @(negedge clk_i);
    rst_n = 1'b1;
  endtask

  // One instruction from first FETCH cycle to its last cycle; returns 1 if the core halted.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int ack_dly, output bit halted);
    logic [7:0] d;
    halted = 0;
    d = ref_decode(op, fn);
    for (int i = 0; i < ack_dly; i++) begin
      if (i > 0) @(negedge clk_i);
      imem_ack_i = 1'b0;
      #1;
      chk("fetch_wait_state", 32'(state_o), 32'd0);
      chk("fetch_wait_req", 32'(imem_req_o), 32'd1);
      chk("fetch_wait_wr", 32'({ir_write_o, pc_write_o}), 32'd0);
      chk("retired", 32'(retired_o), 32'(exp_retired & 16'hFFFF));
    end
    if (ack_dly > 0) @(negedge clk_i);
    imem_ack_i = 1'b1;
    opcode_i = op;
    funct_i = fn;
    zero_i = z;
    #1;
    chk("fetch_state", 32'(state_o), 32'd0);
    chk("fetch_ctl", 32'({imem_req_o, ir_write_o, pc_write_o, pc_src_o, alu_src_a_o, alu_src_b_o, alu_ctrl_o}),
        32'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 4'b0010}));
    chk("retired", 32'(retired_o), 32'(exp_retired & 16'hFFFF));
    @(negedge clk_i);
    imem_ack_i = 1'b0;
    #1;
    chk("decode_state", 32'(state_o), 32'd1);
    chk("decode_ctl", 32'({imem_req_o, tgt_write_o, alu_src_a_o, alu_src_b_o, alu_ctrl_o, reg_write_o, pc_write_o}),
        32'({1'b0, 1'b1, 1'b0, 2'b11, 4'b0010, 1'b0, 1'b0}));
    @(negedge clk_i);
    #1;
    if (op == 6'b000100) begin
      chk("branch_state", 32'(state_o), 32'd4);
      chk("branch_ctl", 32'({alu_src_a_o, alu_src_b_o, alu_ctrl_o, pc_src_o, pc_write_o, reg_write_o}),
          32'({1'b1, 2'b00, 4'b0110, 1'b1, z, 1'b0}));
      exp_retired++;
    end else if (d[7]) begin
      chk("exec_state", 32'(state_o), 32'd2);
      chk("exec_ctl", 32'({alu_ctrl_o, alu_src_b_o, imm_zext_o, shamt_sel_o, reg_write_o}),
          32'({d[3:0], d[6] ? 2'b00 : 2'b10, d[4], d[5], 1'b0}));
      if (d[6]) chk("exec_src_a", 32'(alu_src_a_o), 32'd1);
      @(negedge clk_i);
      #1;
      chk("wb_state", 32'(state_o), 32'd3);
      chk("wb_ctl", 32'({reg_write_o, reg_dst_o, alu_ctrl_o, alu_src_b_o, imm_zext_o, shamt_sel_o, pc_write_o}),
          32'({1'b1, d[6], d[3:0], d[6] ? 2'b00 : 2'b10, d[4], d[5], 1'b0}));
      exp_retired++;
    end else begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      for (int i = 0; i < 10; i++) begin
        if (i > 0) begin @(negedge clk_i); #1; end
        chk("halt_state", 32'(state_o), 32'd5);
        chk("halt_strobes", 32'(strobes()), 32'd0);
        chk("halt_retired", 32'(retired_o), 32'(exp_retired & 16'hFFFF));
      end
      halted = 1;
`else
      chk("illegal_state", 32'(state_o), 32'd0);
      chk("illegal_regwr", 32'(reg_write_o), 32'd0);
      chk("illegal_retired", 32'(retired_o), 32'(exp_retired & 16'hFFFF));
`endif
    end
    @(negedge clk_i);
  endtask

  logic [5:0] pool_op [16];
  logic [5:0] pool_fn [16];

  initial begin
    bit h;
    int k;
    logic [5:0] fn;
    rst_n = 1'b0;
    opcode_i = '0;
    funct_i = '0;
    zero_i = 1'b0;
    imem_ack_i = 1'b0;
    #2;
    do_reset();

    // Three unacknowledged fetch cycles, then ADD.
    run_instr(6'b000000, 6'b010011, 1'b0, 3, h);
    chk("add_retired", 32'(retired_o), 32'd1);
    run_instr(6'b000100, 6'b000000, 1'b1, 0, h);
    run_instr(6'b000100, 6'b000000, 1'b0, 0, h);
    run_instr(6'b001101, 6'b101010, 1'b0, 0, h);
    run_instr(6'b001111, 6'b000000, 1'b0, 1, h);
    run_instr(6'b000000, 6'b000000, 1'b0, 0, h);
    run_instr(6'b111111, 6'b000000, 1'b0, 0, h);
    if (h) do_reset();

    // Reset pulse in the middle of WB.
    imem_ack_i = 1'b1;
    opcode_i = 6'b000000;
    funct_i = 6'b010011;
    #1;
    repeat (3) @(negedge clk_i);
    #1;
    chk("wb_before_rst", 32'({state_o, reg_write_o}), 32'({3'd3, 1'b1}));
    rst_n = 1'b0;
    #1;
    chk("wb_rst_regwr", 32'(reg_write_o), 32'd0);
    chk("wb_rst_state", 32'(state_o), 32'd0);
    chk("wb_rst_retired", 32'(retired_o), 32'd0);
    exp_retired = 0;
    imem_ack_i = 1'b0;
    @(negedge clk_i);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req", 32'(imem_req_o), 32'd1);

    pool_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                6'h00, 6'h00, 6'h08, 6'h0D, 6'h0F, 6'h04, 6'h3F, 6'h00};
    pool_fn = '{6'b010011, 6'b010001, 6'b010100, 6'b010110, 6'b110000, 6'b010101,
                6'b000000, 6'b000010, 6'b000110, 6'b000100, 6'h00, 6'h00, 6'h00,
                6'h00, 6'h00, 6'b111111};
    for (int n = 0; n < 60; n++) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      k = int'($urandom_range(0, 13));
`else
      k = int'($urandom_range(0, 15));
`endif
      fn = pool_fn[k];
      if (pool_op[k] != 6'h00) fn = 6'($urandom);
      run_instr(pool_op[k], fn, 1'($urandom), int'($urandom_range(0, 2)), h);
      if (h) do_reset();
    end
    #1;
    chk("final_retired", 32'(retired_o), 32'(exp_retired & 16'hFFFF));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
